// File: rtl/mul_div_unit.sv
// Iterative 64-bit multiply/divide unit: one radix-2 step per clock, fixed latency for every op.
// Result is returned through the register-bank write port (wr_reg/result/wr_en).
module mul_div_unit #(
  parameter int WIDTH  = 64,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [WIDTH-1:0]  operand_a,
  input  logic [WIDTH-1:0]  operand_b,
  input  logic [REG_AW-1:0] dest_reg,
  input  logic              kill,
  output logic              busy,
  output logic              done,
  output logic [WIDTH-1:0]  result,
  output logic [REG_AW-1:0] wr_reg,
  output logic              wr_en
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, BUSY, FINISH, DONE} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     count_q, count_d;
  logic [1:0]        op_q, op_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [WIDTH-1:0]  hi_q, hi_d;
  logic [WIDTH-1:0]  lo_q, lo_d;
  logic [WIDTH-1:0]  result_q, result_d;
  logic              neg_q, neg_d;
  logic              done_q, done_d;
  logic [REG_AW-1:0] wr_reg_q, wr_reg_d;

  logic [WIDTH:0]    add_sum;
  logic [WIDTH:0]    div_shift;
  logic [WIDTH:0]    div_diff;
  logic [WIDTH-1:0]  a_mag;
  logic [WIDTH-1:0]  b_mag;
  logic [WIDTH-1:0]  quot;
  logic              is_sdiv;

  // hi holds the upper accumulator (MUL) or partial remainder (DIV); lo holds multiplier/quotient.
  assign is_sdiv   = (op == 2'b11);
  assign a_mag     = (is_sdiv && operand_a[WIDTH-1]) ? -operand_a : operand_a;
  assign b_mag     = (is_sdiv && operand_b[WIDTH-1]) ? -operand_b : operand_b;
  assign add_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
  assign div_shift = {hi_q, lo_q[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, b_q};
  assign quot      = neg_q ? -lo_q : lo_q;

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    op_d     = op_q;
    b_d      = b_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    result_d = result_q;
    neg_d    = neg_q;
    done_d   = 1'b0;
    wr_reg_d = wr_reg_q;
    case (state_q)
      IDLE: begin
        if (start && !kill) begin
          state_d  = BUSY;
          count_d  = '0;
          op_d     = op;
          hi_d     = '0;
          lo_d     = a_mag;
          b_d      = b_mag;
          neg_d    = is_sdiv && (operand_a[WIDTH-1] ^ operand_b[WIDTH-1]);
          wr_reg_d = dest_reg;
        end
      end
      BUSY: begin
        if (kill) begin
          state_d = IDLE;
        end else begin
          count_d = count_q + CW'(1);
          if (count_q == CW'(WIDTH-1)) state_d = FINISH;
          if (!op_q[1]) begin
            hi_d = add_sum[WIDTH:1];
            lo_d = {add_sum[0], lo_q[WIDTH-1:1]};
          end else if (!div_diff[WIDTH]) begin
            hi_d = div_diff[WIDTH-1:0];
            lo_d = {lo_q[WIDTH-2:0], 1'b1};
          end else begin
            hi_d = div_shift[WIDTH-1:0];
            lo_d = {lo_q[WIDTH-2:0], 1'b0};
          end
        end
      end
      FINISH: begin
        if (kill) begin
          state_d = IDLE;
        end else begin
          case (op_q)
            2'b00:   result_d = lo_q;
            2'b01:   result_d = hi_q;
            default: result_d = (b_q == '0) ? '0 : quot;
          endcase
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      count_q  <= '0;
      op_q     <= '0;
      b_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      result_q <= '0;
      neg_q    <= 1'b0;
      done_q   <= 1'b0;
      wr_reg_q <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      op_q     <= op_d;
      b_q      <= b_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      result_q <= result_d;
      neg_q    <= neg_d;
      done_q   <= done_d;
      wr_reg_q <= wr_reg_d;
    end
  end

  assign busy   = (state_q != IDLE);
  assign done   = done_q;
  assign wr_en  = done_q;
  assign result = result_q;
  assign wr_reg = wr_reg_q;
endmodule
